noc_phase_sequencer: RTL
========================

// Module: noc_phase_sequencer
// PURPOSE
//  Synthesizable, parametrised run controller for the NoC. It sequences router init,
//  routing-table load, traffic fill and the LoadStaging/Phase0/Phase1 cycle loop for
//  NUM_ROUTERS routers, and tracks the simulated-cycle count up to max_cycle.
//  Adds early termination, abort, and a configurable traffic-fill interval.
// PARAMETERS
//  NUM_ROUTERS    16  routers driven (>=2)
//  ROUTER_BITS     4  clog2(NUM_ROUTERS)
//  PORT_BITS       3  out-port index width
//  OP_BITS         3  router op width
//  CYCLE_BITS     16  simulated-cycle counter width
//  FILL_INTERVAL   1  fill pass every N simulated cycles; 0 = fill never
// PORTS
//  clk           in   1            clock
//  rst_n         in   1            async reset, active low
//  start         in   1            begin run (pulse); ignored unless IDLE or DONE
//  abort         in   1            stop run, return to IDLE
//  max_cycle     in   CYCLE_BITS   sampled at start; simulated-cycle limit
//  rt_rd_addr    out  2*ROUTER_BITS {src,dst} routing-table read address
//  rt_rd_data    in   PORT_BITS    out-port for rt_rd_addr, 1-cycle read latency
//  rt_rd_valid   in   1            entry present (qualifies rt_rd_data)
//  router_done   in   NUM_ROUTERS  per-router drained flag
//  fill_req      out  1            traffic fill request
//  fill_ack      in   1            fill accepted
//  fill_empty    in   1            no traffic left in sources
//  router_op     out  OP_BITS      op: NOP=0 Init=1 LoadRt=2 LoadStaging=3 Phase0=4 Phase1=5
//  router_op_en  out  NUM_ROUTERS  per-router op enable (unselected routers see NOP)
//  rt_dst        out  ROUTER_BITS  LoadRt destination
//  rt_outport    out  PORT_BITS    LoadRt out-port
//  in_cycle      out  CYCLE_BITS   simulated cycle count
//  busy          out  1            state not IDLE/DONE
//  finished      out  1            run completed normally
// BEHAVIOUR
//  Reset: every output 0; state IDLE; counters 0. All outputs registered.
//  States: IDLE, INIT, RT_REQ, RT_LOAD, FILL, STAGE, PH0, PH1, DONE.
//  IDLE/DONE --start--> INIT: clear in_cycle, finished; latch max_cycle.
//  INIT (1 cyc): router_op=Init, router_op_en=all ones -> RT_REQ with src=dst=0.
//  RT_REQ (1 cyc): drive rt_rd_addr={src,dst}, router_op=NOP -> RT_LOAD.
//  RT_LOAD (1 cyc): if rt_rd_valid: router_op=LoadRt, router_op_en=onehot(src),
//   rt_dst=dst, rt_outport=rt_rd_data; else router_op=NOP, en=0. dst increments; on
//   dst wrap src increments; after src=dst=NUM_ROUTERS-1 -> loop entry, else RT_REQ.
//   Full load = 2*NUM_ROUTERS^2 cycles.
//  Loop entry: if latched max_cycle==0 -> DONE; else FILL if fill due, else STAGE.
//  Fill due: FILL_INTERVAL!=0 and in_cycle % FILL_INTERVAL==0 and !fill_empty.
//  FILL: fill_req=1 held until the cycle fill_ack=1; deassert next cycle -> STAGE.
//  STAGE, PH0, PH1: one cycle each, router_op=LoadStaging/Phase0/Phase1, en=all ones.
//  PH1: in_cycle+1 (wraps at 2^CYCLE_BITS). Next: DONE if new in_cycle==max_cycle or
//   (&router_done && fill_empty); else fill-due check -> FILL or STAGE.
//  DONE: router_op=NOP, finished=1 held until next start; busy=0.
//  abort (any state, priority over all): next cycle IDLE, op=NOP, en=0, fill_req=0,
//   finished=0; in_cycle held for inspection.
//  start while busy: ignored. start and abort same cycle: abort wins.
//  rst_n low mid-run: immediate return to reset values.
// TESTING (NUM_ROUTERS=4, FILL_INTERVAL=2)
//  Reset mid-PH0 -> all outputs 0 same cycle, state IDLE.
//  start, max_cycle=3, table only (0,2)=1,(3,1)=2 -> 1 Init, exactly 2 LoadRt pulses
//   with en=0001/dst=2/outport=1 and en=1000/dst=1/outport=2; 32 RT cycles.
//  Same run, fill_ack after 3 cycles -> fill_req high 3 cycles at in_cycle 0 and 2,
//   not 1; finished=1 with in_cycle=3.
//  router_done=1111, fill_empty=1 from start, max_cycle=100 -> DONE after first PH1, in_cycle=1.
//  max_cycle=0 -> DONE right after RT load, no LoadStaging issued.
//  abort during FILL with fill_req=1 -> next cycle IDLE, fill_req=0, finished=0;
//   start ignored while busy, accepted from IDLE.

Source files
------------

// File: rtl/noc_phase_sequencer.sv
// noc_phase_sequencer: run controller for the NoC router array.
// Sequences router init, routing-table load, traffic fill and the
// LoadStaging/Phase0/Phase1 loop, counting simulated cycles up to max_cycle.
// Router-facing outputs (op, enable, fill request, load payload) are the
// registered decode of the state just left, so they trail the state by one
// cycle. The routing-table address and the status outputs (busy, finished,
// in_cycle) are registered from the next state and line up with it.
module noc_phase_sequencer #(
   parameter int unsigned NUM_ROUTERS   = 16,
   parameter int unsigned ROUTER_BITS   = 4,
   parameter int unsigned PORT_BITS     = 3,
   parameter int unsigned OP_BITS       = 3,
   parameter int unsigned CYCLE_BITS    = 16,
   parameter int unsigned FILL_INTERVAL = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [CYCLE_BITS-1:0]    max_cycle,
   output logic [2*ROUTER_BITS-1:0] rt_rd_addr,
   input  logic [PORT_BITS-1:0]     rt_rd_data,
   input  logic                     rt_rd_valid,
   input  logic [NUM_ROUTERS-1:0]   router_done,
   output logic                     fill_req,
   input  logic                     fill_ack,
   input  logic                     fill_empty,
   output logic [OP_BITS-1:0]       router_op,
   output logic [NUM_ROUTERS-1:0]   router_op_en,
   output logic [ROUTER_BITS-1:0]   rt_dst,
   output logic [PORT_BITS-1:0]     rt_outport,
   output logic [CYCLE_BITS-1:0]    in_cycle,
   output logic                     busy,
   output logic                     finished
);

   localparam int unsigned FI_SAFE = (FILL_INTERVAL == 0) ? 1 : FILL_INTERVAL;

   localparam logic [CYCLE_BITS-1:0]  FI_C      = CYCLE_BITS'(FI_SAFE);
   localparam logic [ROUTER_BITS-1:0] LAST_RTR  = ROUTER_BITS'(NUM_ROUTERS - 1);
   localparam logic [NUM_ROUTERS-1:0] ALL_EN    = {NUM_ROUTERS{1'b1}};

   localparam logic [OP_BITS-1:0] OP_NOP    = OP_BITS'(0);
   localparam logic [OP_BITS-1:0] OP_INIT   = OP_BITS'(1);
   localparam logic [OP_BITS-1:0] OP_LOADRT = OP_BITS'(2);
   localparam logic [OP_BITS-1:0] OP_STAGE  = OP_BITS'(3);
   localparam logic [OP_BITS-1:0] OP_PH0    = OP_BITS'(4);
   localparam logic [OP_BITS-1:0] OP_PH1    = OP_BITS'(5);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_INIT    = 4'd1,
      S_RT_REQ  = 4'd2,
      S_RT_LOAD = 4'd3,
      S_FILL    = 4'd4,
      S_STAGE   = 4'd5,
      S_PH0     = 4'd6,
      S_PH1     = 4'd7,
      S_DONE    = 4'd8
   } state_t;

   state_t                   state_q, state_d;
   logic [ROUTER_BITS-1:0]   src_q, src_d;
   logic [ROUTER_BITS-1:0]   dst_q, dst_d;
   logic [CYCLE_BITS-1:0]    maxc_q, maxc_d;

   logic [2*ROUTER_BITS-1:0] addr_d;
   logic                     fill_req_d;
   logic [OP_BITS-1:0]       op_d;
   logic [NUM_ROUTERS-1:0]   en_d;
   logic [ROUTER_BITS-1:0]   rt_dst_d;
   logic [PORT_BITS-1:0]     rt_outport_d;
   logic [CYCLE_BITS-1:0]    cyc_d;
   logic                     busy_d;
   logic                     fin_d;

   logic [CYCLE_BITS-1:0]    cyc_inc;
   logic                     all_drained;

   // Fill pass is due on interval boundaries while sources still hold traffic.
   function automatic logic fill_due(input logic [CYCLE_BITS-1:0] cyc,
                                     input logic                  empty);
      fill_due = (FILL_INTERVAL != 0) && ((cyc % FI_C) == '0) && !empty;
   endfunction

   assign cyc_inc     = in_cycle + CYCLE_BITS'(1);
   assign all_drained = &router_done;

   // State, run bookkeeping and all output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         maxc_q       <= '0;
         rt_rd_addr   <= '0;
         fill_req     <= 1'b0;
         router_op    <= OP_NOP;
         router_op_en <= '0;
         rt_dst       <= '0;
         rt_outport   <= '0;
         in_cycle     <= '0;
         busy         <= 1'b0;
         finished     <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         maxc_q       <= maxc_d;
         rt_rd_addr   <= addr_d;
         fill_req     <= fill_req_d;
         router_op    <= op_d;
         router_op_en <= en_d;
         rt_dst       <= rt_dst_d;
         rt_outport   <= rt_outport_d;
         in_cycle     <= cyc_d;
         busy         <= busy_d;
         finished     <= fin_d;
      end
   end

   // Next-state and next-output decode; abort overrides everything.
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      maxc_d       = maxc_q;
      addr_d       = rt_rd_addr;
      fill_req_d   = 1'b0;
      op_d         = OP_NOP;
      en_d         = '0;
      rt_dst_d     = rt_dst;
      rt_outport_d = rt_outport;
      cyc_d        = in_cycle;
      fin_d        = finished;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_INIT;
               cyc_d   = '0;
               fin_d   = 1'b0;
               maxc_d  = max_cycle;
            end
         end
         S_INIT: begin
            op_d    = OP_INIT;
            en_d    = ALL_EN;
            src_d   = '0;
            dst_d   = '0;
            state_d = S_RT_REQ;
         end
         S_RT_REQ: begin
            state_d = S_RT_LOAD;
         end
         S_RT_LOAD: begin
            if (rt_rd_valid) begin
               op_d         = OP_LOADRT;
               en_d         = NUM_ROUTERS'(1) << src_q;
               rt_dst_d     = dst_q;
               rt_outport_d = rt_rd_data;
            end
            if (dst_q == LAST_RTR) begin
               dst_d = '0;
               if (src_q == LAST_RTR) begin
                  src_d = '0;
                  if (maxc_q == '0) begin
                     state_d = S_DONE;
                     fin_d   = 1'b1;
                  end else if (fill_due(in_cycle, fill_empty)) begin
                     state_d = S_FILL;
                  end else begin
                     state_d = S_STAGE;
                  end
               end else begin
                  src_d   = src_q + ROUTER_BITS'(1);
                  state_d = S_RT_REQ;
               end
            end else begin
               dst_d   = dst_q + ROUTER_BITS'(1);
               state_d = S_RT_REQ;
            end
         end
         S_FILL: begin
            // Request stays up until it has been seen and acknowledged.
            if (fill_ack && fill_req) begin
               fill_req_d = 1'b0;
               state_d    = S_STAGE;
            end else begin
               fill_req_d = 1'b1;
            end
         end
         S_STAGE: begin
            op_d    = OP_STAGE;
            en_d    = ALL_EN;
            state_d = S_PH0;
         end
         S_PH0: begin
            op_d    = OP_PH0;
            en_d    = ALL_EN;
            state_d = S_PH1;
         end
         S_PH1: begin
            op_d  = OP_PH1;
            en_d  = ALL_EN;
            cyc_d = cyc_inc;
            if ((cyc_inc == maxc_q) || (all_drained && fill_empty)) begin
               state_d = S_DONE;
               fin_d   = 1'b1;
            end else if (fill_due(cyc_inc, fill_empty)) begin
               state_d = S_FILL;
            end else begin
               state_d = S_STAGE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort) begin
         state_d    = S_IDLE;
         op_d       = OP_NOP;
         en_d       = '0;
         fill_req_d = 1'b0;
         fin_d      = 1'b0;
         cyc_d      = in_cycle;
      end

      // Table address lines up with RT_REQ so read data lands in RT_LOAD.
      if (state_d == S_RT_REQ) begin
         addr_d = {src_d, dst_d};
      end

      busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
   end

endmodule
